// File: rtl/ins_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : ins_fetcher
// Purpose  : Instruction fetch stage. Holds the program counter, requests
//            instructions from the iCache, statically predicts the next PC
//            (JAL taken, everything else pc+4) and buffers fetched
//            instructions in a circular queue feeding the decoder.
// Ports    : clk, rst (sync, active-high), rdy (global enable),
//            clr / in_clr_pc (flush + redirect),
//            out_to_iCache_valid/addr, in_from_iCache_hit/ins,
//            out_to_decoder_valid/ins/pc/pred_pc, in_from_decoder_ready
// Revision : 1.0 - initial release
// ============================================================================
module ins_fetcher #(
    parameter int          IQ_DEPTH = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic [31:0] in_clr_pc,
    output logic        out_to_iCache_valid,
    output logic [31:0] out_to_iCache_addr,
    input  logic        in_from_iCache_hit,
    input  logic [31:0] in_from_iCache_ins,
    output logic        out_to_decoder_valid,
    output logic [31:0] out_to_decoder_ins,
    output logic [31:0] out_to_decoder_pc,
    output logic [31:0] out_to_decoder_pred_pc,
    input  logic        in_from_decoder_ready
);

    localparam int               c_ptr_w    = $clog2(IQ_DEPTH);
    localparam int               c_cnt_w    = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(IQ_DEPTH);
    localparam logic [6:0]       c_op_jal   = 7'b1101111;

    logic [31:0]        r_pc;
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;

    logic [31:0] r_q_ins  [IQ_DEPTH];
    logic [31:0] r_q_pc   [IQ_DEPTH];
    logic [31:0] r_q_pred [IQ_DEPTH];

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_jal_imm;
    logic [31:0] w_pred;

    assign w_full  = (r_count == c_full_cnt);
    assign w_empty = (r_count == '0);

    // The request drops while a clear is in flight so nothing fetched from
    // the stale path can be enqueued on the redirect edge.
    assign out_to_iCache_valid = !w_full && !clr;
    assign out_to_iCache_addr  = r_pc;

    assign w_push = rdy && out_to_iCache_valid && in_from_iCache_hit;
    assign w_pop  = rdy && !w_empty && in_from_decoder_ready;

    // J-type immediate, sign-extended from bit 31.
    assign w_jal_imm = {{11{in_from_iCache_ins[31]}}, in_from_iCache_ins[31],
                        in_from_iCache_ins[19:12], in_from_iCache_ins[20],
                        in_from_iCache_ins[30:21], 1'b0};

    // Static prediction: only JAL is known-taken at fetch time; branches are
    // predicted not taken and JALR falls through to pc+4.
    assign w_pred = (in_from_iCache_ins[6:0] == c_op_jal) ? (r_pc + w_jal_imm)
                                                         : (r_pc + 32'd4);

    // Head outputs are forced to zero while the queue is empty so stale
    // entries never leak to the decoder.
    assign out_to_decoder_valid   = !w_empty;
    assign out_to_decoder_ins     = w_empty ? 32'h0 : r_q_ins[r_head];
    assign out_to_decoder_pc      = w_empty ? 32'h0 : r_q_pc[r_head];
    assign out_to_decoder_pred_pc = w_empty ? 32'h0 : r_q_pred[r_head];

    // Control state: pc, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (clr) begin
                r_pc    <= in_clr_pc;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_pc   <= w_pred;
                    r_tail <= r_tail + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + c_ptr_w'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_cnt_w'(1);
                    2'b01:   r_count <= r_count - c_cnt_w'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage needs no reset: entries are only observed when counted.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_q_ins[r_tail]  <= in_from_iCache_ins;
            r_q_pc[r_tail]   <= r_pc;
            r_q_pred[r_tail] <= w_pred;
        end
    end

endmodule
`default_nettype wire
